// File: rtl/chip2chip_master_ctrl_if.sv
// chip2chip_master_ctrl_if: initiator-side pins of the req/ack/valid link,
// plus the local send/data_sw/status signals.
interface chip2chip_master_ctrl_if #(
  parameter int DATA_W = 3
);
  logic              send;
  logic [DATA_W-1:0] data_sw;
  logic              ack;
  logic              request;
  logic              valid;
  logic [DATA_W-1:0] data_out;
  logic              notice;
  logic              busy;
  logic              done;
  logic              timeout;

  modport master (
    input  send, data_sw, ack,
    output request, valid, data_out,
    output notice, busy, done, timeout
  );

  modport slave (
    output send, data_sw, ack,
    input  request, valid, data_out,
    input  notice, busy, done, timeout
  );
endinterface

// File: rtl/chip2chip_master_ctrl.sv
// chip2chip_master_ctrl: initiator FSM for the req/ack/valid chip link.
// Optional REQ ack timeout enabled by defining C2C_ACK_TIMEOUT_EN.
module chip2chip_master_ctrl #(
  parameter int DATA_W         = 3,
  parameter int CNT_W          = 27,
  parameter int HOLD_CYCLES    = 100000000,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input logic clk,
  input logic rst_n,
  chip2chip_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SEND    = 2'b10,
    RELEASE = 2'b11
  } state_t;

`ifdef C2C_ACK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DATA_W-1:0] word, word_d;
  logic              good, good_d;
  logic              done_d, tmo_d;
  logic              ack_q, ack_s;

  logic              request_q, valid_q;
  logic              notice_q, busy_q;
  logic              done_q, timeout_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      good      <= 1'b0;
      ack_q     <= 1'b0;
      ack_s     <= 1'b0;
      request_q <= 1'b0;
      valid_q   <= 1'b0;
      notice_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      word      <= word_d;
      good      <= good_d;
      ack_q     <= bus.ack;
      ack_s     <= ack_q;
      // outputs follow the state being entered
      request_q <= (state_d == REQ) ||
                   (state_d == SEND);
      valid_q   <= (state_d == SEND);
      notice_q  <= (state_d == REQ);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      timeout_q <= tmo_d;
      data_q    <= (state_d == SEND) ? word_d : '0;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    word_d  = word;
    good_d  = good;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (bus.send && !ack_s) begin
          word_d  = bus.data_sw;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = SEND;
          cnt_d   = '0;
          good_d  = 1'b1;
        end else if (TMO_EN && cnt == TMO_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else if (TMO_EN) begin
          cnt_d = cnt + 1'b1;
        end
      end
      SEND: begin
        if (cnt == HOLD_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RELEASE: begin
        cnt_d = '0;
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = good;
          good_d  = 1'b0;
        end
      end
    endcase
  end

  assign bus.request  = request_q;
  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;
  assign bus.notice   = notice_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_chip2chip_master_ctrl.sv
// tb_chip2chip_master_ctrl: randomized transfers against a timeline model
// of the link (send/ack edges -> expected output windows).
module tb_chip2chip_master_ctrl;

  localparam int DATA_W   = 3;
  localparam int HOLD     = 4;
  localparam int TMO      = 20;
  localparam int SYNC_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  chip2chip_master_ctrl_if #(.DATA_W(DATA_W)) bus ();

  chip2chip_master_ctrl #(
    .DATA_W(DATA_W),
    .CNT_W(27),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [8:0] outs();
    return {bus.request, bus.valid, bus.notice,
            bus.busy, bus.done, bus.timeout,
            bus.data_out};
  endfunction

  task automatic test_reset();
    bus.ack = 1'b1;
    bus.send = 1'b0;
    bus.data_sw = '0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (outs() !== 9'd0) begin
      errors++;
      $display("FAIL reset_outs got=%b want=0", outs());
    end
    checks++;
    if (dut.ack_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack_s got=%b want=0", dut.ack_s);
    end
    rst_n = 1'b1;
    bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (outs() !== 9'd0) begin
      errors++;
      $display("FAIL post_reset_idle got=%b want=0", outs());
    end
  endtask

  // Send after tick s; ack high after ticks [a, d).
  // ack seen by FSM SYNC_LAT edges later, outputs one more edge.
  task automatic run_transfer(
    input string            name,
    input logic [DATA_W-1:0] w,
    input int               lat,
    input int               hold_after,
    input bit               inject
  );
    int s, a, d, rise, fall, dn, t;
    logic [8:0] exp;
    logic e_req, e_val, e_not, e_busy, e_done;
    s = cyc;
    a = s + 1 + lat;
    d = a + 1 + hold_after;
    rise = a + SYNC_LAT + 1;
    fall = rise + HOLD;
    dn = (fall + 1 > d + SYNC_LAT + 1) ? fall + 1 : d + SYNC_LAT + 1;
    bus.send = 1'b1;
    bus.data_sw = w;
    bus.ack = 1'b0;
    while (cyc < dn + 2) begin
      tick();
      t = cyc;
      e_req  = (t > s) && (t < fall);
      e_val  = (t >= rise) && (t < fall);
      e_not  = (t > s) && (t < rise);
      e_busy = (t > s) && (t < dn);
      e_done = (t == dn);
      exp = {e_req, e_val, e_not, e_busy, e_done, 1'b0,
             e_val ? w : {DATA_W{1'b0}}};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL %s t=%0d got=%b want=%b", name, t - s, outs(), exp);
      end
      bus.send = inject && (t < dn - 1) && ($urandom_range(0, 2) == 0);
      bus.data_sw = bus.send ? 3'b010 : $urandom_range(0, 7);
      bus.ack = (t >= a) && (t < d);
    end
    bus.send = 1'b0;
    bus.ack = 1'b0;
  endtask

  task automatic test_normal();
    run_transfer("normal", 3'b101, 5, HOLD + 4, 1'b0);
  endtask

  task automatic test_ignore_send();
    run_transfer("ignore_send", 3'b101, 3, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      run_transfer("b2b", DATA_W'($urandom_range(0, 7)),
                   $urandom_range(0, 8),
                   $urandom_range(0, HOLD + 6),
                   1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_stale_ack();
    bus.ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.send = 1'b1;
    bus.data_sw = 3'b111;
    tick();
    bus.send = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.request !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL stale_ack req=%b busy=%b want 0/0", bus.request, bus.busy);
      end
    end
    bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bus.send = 1'b1;
    bus.data_sw = 3'b110;
    tick();
    bus.send = 1'b0;
    bus.ack = 1'b1;
    n = 0;
    while (bus.valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach got=%b want=1", bus.valid);
    end
    tick();
    rst_n = 1'b0;
    bus.ack = 1'b0;
    tick();
    checks++;
    if (outs() !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_outs got=%b want=0", outs());
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_done done=%b busy=%b want 0/0", bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    bus.ack = 1'b0;
    bus.send = 1'b1;
    bus.data_sw = 3'b011;
    tick();
    bus.send = 1'b0;
    n = 0;
    while (bus.request === 1'b1 && n < 2 * TMO) begin
      n++;
      tick();
    end
`ifdef C2C_ACK_TIMEOUT_EN
    checks++;
    if (n !== TMO) begin
      errors++;
      $display("FAIL timeout_len got=%0d want=%0d", n, TMO);
    end
    checks++;
    if (bus.timeout !== 1'b1 || bus.request !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse tmo=%b req=%b want 1/0", bus.timeout, bus.request);
    end
    tick();
    checks++;
    if ({bus.timeout, bus.done, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle tmo/done/busy=%b want 000",
               {bus.timeout, bus.done, bus.busy});
    end
`else
    checks++;
    if (n !== 2 * TMO || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout len=%0d tmo=%b want %0d/0", n, bus.timeout, 2 * TMO);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (outs() !== 9'd0) begin
      errors++;
      $display("FAIL timeout_end got=%b want=0", outs());
    end
  endtask

  initial begin
    bus.send = 1'b0;
    bus.data_sw = '0;
    bus.ack = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_normal();
    test_ignore_send();
    test_stale_ack();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
